// File: rtl/gate_reduce_pipe.sv
// rtl/gate_reduce_pipe.sv - pipelined FANIN-ary reduction gate (OR/AND/XOR/NOR) with valid/ready flow control
module gate_reduce_pipe #(
    parameter int WIDTH = 8,
    parameter int FANIN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [1:0]       out_op
);

    function automatic int calc_levels(input int w, input int f);
        int l;
        int p;
        l = 1;
        p = f;
        for (int i = 0; i < 7; i++) begin
            if (p < w) begin
                p = p * f;
                l = l + 1;
            end
        end
        return l;
    endfunction

    // Partial-bit count after k tree levels: ceil(WIDTH / FANIN^k).
    function automatic int stage_width(input int w, input int f, input int k);
        int n;
        n = w;
        for (int i = 0; i < k; i++) begin
            n = (n + f - 1) / f;
        end
        return n;
    endfunction

    localparam int LEVELS = calc_levels(WIDTH, FANIN);

    logic [LEVELS-1:0] valid;
    logic [LEVELS-1:0] load;

    // A stage may load when any stage at or after it has a hole, or the consumer drains.
    always_comb begin
        logic chain;
        load  = '0;
        chain = out_ready;
        for (int k = LEVELS - 1; k >= 0; k--) begin
            chain   = chain | ~valid[k];
            load[k] = chain;
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid[LEVELS-1];

    for (genvar k = 0; k < LEVELS; k++) begin : g_stage
        localparam int WI   = stage_width(WIDTH, FANIN, k);
        localparam int WO   = stage_width(WIDTH, FANIN, k + 1);
        localparam bit LAST = (k == LEVELS - 1);

        logic [WI-1:0]       src_data;
        logic [1:0]          src_op;
        logic                src_valid;
        logic [WO*FANIN-1:0] padded;
        logic [WO-1:0]       reduced;
        logic                ident;
        logic                acc;
        logic [WO-1:0]       data_q;
        logic [1:0]          op_q;
        logic                valid_q;

        if (k == 0) begin : g_src
            assign src_data  = in_data;
            assign src_op    = in_op;
            assign src_valid = in_valid;
        end else begin : g_src
            assign src_data  = g_stage[k-1].data_q;
            assign src_op    = g_stage[k-1].op_q;
            assign src_valid = g_stage[k-1].valid_q;
        end

        // NOR runs as OR through the tree and is inverted only at the last level.
        always_comb begin
            ident            = (src_op == 2'b01);
            padded           = {(WO*FANIN){ident}};
            padded[WI-1:0]   = src_data;
            reduced          = '0;
            acc              = 1'b0;
            for (int j = 0; j < WO; j++) begin
                acc = ident;
                for (int i = 0; i < FANIN; i++) begin
                    case (src_op)
                        2'b01:   acc = acc & padded[j*FANIN+i];
                        2'b10:   acc = acc ^ padded[j*FANIN+i];
                        default: acc = acc | padded[j*FANIN+i];
                    endcase
                end
                if (LAST && (src_op == 2'b11)) begin
                    acc = ~acc;
                end
                reduced[j] = acc;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                op_q    <= 2'b00;
            end else if (load[k]) begin
                valid_q <= src_valid;
                if (src_valid) begin
                    data_q <= reduced;
                    op_q   <= src_op;
                end
            end
        end

        assign valid[k] = valid_q;

        if (LAST) begin : g_out
            assign out_bit = data_q[0];
            assign out_op  = op_q;
        end
    end

endmodule

// File: tb/tb_gate_reduce_pipe.sv
// tb/tb_gate_reduce_pipe.sv - directed self-checking bench for gate_reduce_pipe
module tb_gate_reduce_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid, in_ready, out_valid, out_ready, out_bit;
    logic [7:0]  in_data;
    logic [1:0]  in_op, out_op;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_bit;
    logic [15:0] b_in_data;
    logic [1:0]  b_in_op, b_out_op;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gate_reduce_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_op(out_op)
    );

    gate_reduce_pipe #(.WIDTH(16), .FANIN(4)) dut_w16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_op(b_in_op),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bit(b_out_bit), .out_op(b_out_op)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run3(input string tag,
                        input logic [7:0] d0, input logic [1:0] o0, input logic e0,
                        input logic [7:0] d1, input logic [1:0] o1, input logic e1,
                        input logic [7:0] d2, input logic [1:0] o2, input logic e2);
        in_valid = 1'b1; in_data = d0; in_op = o0;
        #1;
        chk({tag, "_ready"}, 16'(in_ready), 16'd1);
        cyc();
        chk({tag, "_lat"}, 16'(out_valid), 16'd0);
        in_data = d1; in_op = o1;
        cyc();
        chk({tag, "_v0"}, 16'(out_valid), 16'd1);
        chk({tag, "_b0"}, 16'(out_bit), 16'(e0));
        chk({tag, "_o0"}, 16'(out_op), 16'(o0));
        in_data = d2; in_op = o2;
        cyc();
        chk({tag, "_v1"}, 16'(out_valid), 16'd1);
        chk({tag, "_b1"}, 16'(out_bit), 16'(e1));
        chk({tag, "_o1"}, 16'(out_op), 16'(o1));
        in_valid = 1'b0;
        cyc();
        chk({tag, "_v2"}, 16'(out_valid), 16'd1);
        chk({tag, "_b2"}, 16'(out_bit), 16'(e2));
        chk({tag, "_o2"}, 16'(out_op), 16'(o2));
        cyc();
        chk({tag, "_empty"}, 16'(out_valid), 16'd0);
    endtask

    initial begin
        logic [7:0] bd [5];
        logic [1:0] bo [5];
        logic       be [5];
        logic       hb;
        logic [1:0] ho;
        int         sent;
        int         got;

        in_valid = 1'b0; in_data = 8'h00; in_op = 2'b00; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = 16'h0000; b_in_op = 2'b00; b_out_ready = 1'b1;
        hb = 1'b0; ho = 2'b00;

        // Reset held for 3 cycles
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_out_bit", 16'(out_bit), 16'd0);
        chk("rst_out_op", 16'(out_op), 16'd0);
        repeat (3) cyc();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 16'(in_ready), 16'd1);

        // Asynchronous mid-cycle pulse clears a held result immediately
        cyc();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h00; in_op = 2'b11;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("apulse_pre_valid", 16'(out_valid), 16'd1);
        chk("apulse_pre_bit", 16'(out_bit), 16'd1);
        chk("apulse_pre_op", 16'(out_op), 16'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("apulse_valid", 16'(out_valid), 16'd0);
        chk("apulse_bit", 16'(out_bit), 16'd0);
        chk("apulse_op", 16'(out_op), 16'd0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("apulse_after", 16'(out_valid), 16'd0);

        run3("or_nor", 8'h00, 2'b00, 1'b0, 8'h10, 2'b00, 1'b1, 8'h00, 2'b11, 1'b1);
        run3("and_pad", 8'hFF, 2'b01, 1'b1, 8'hFE, 2'b01, 1'b0, 8'h7F, 2'b01, 1'b0);
        run3("xor_par", 8'hA7, 2'b10, 1'b1, 8'h81, 2'b10, 1'b0, 8'h01, 2'b10, 1'b1);

        // WIDTH=16, FANIN=4 parity
        b_in_valid = 1'b1; b_in_data = 16'h8001; b_in_op = 2'b10;
        cyc();
        b_in_data = 16'h8000;
        cyc();
        chk("w16_v0", 16'(b_out_valid), 16'd1);
        chk("w16_b0", 16'(b_out_bit), 16'd0);
        b_in_valid = 1'b0;
        cyc();
        chk("w16_v1", 16'(b_out_valid), 16'd1);
        chk("w16_b1", 16'(b_out_bit), 16'd1);
        cyc();
        chk("w16_empty", 16'(b_out_valid), 16'd0);

        // Backpressure: out_ready low for loop cycles 3..6
        bd = '{8'h01, 8'hFF, 8'h03, 8'h00, 8'h07};
        bo = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
        be = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        sent = 0;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 5);
            in_data   = bd[(sent < 5) ? sent : 0];
            in_op     = bo[(sent < 5) ? sent : 0];
            #1;
            if (c == 3) begin
                chk("bp_in_ready_full", 16'(in_ready), 16'd0);
                hb = out_bit;
                ho = out_op;
            end
            if (c > 3 && c <= 6) begin
                chk("bp_hold_valid", 16'(out_valid), 16'd1);
                chk("bp_hold_bit", 16'(out_bit), 16'(hb));
                chk("bp_hold_op", 16'(out_op), 16'(ho));
            end
            if (out_valid && out_ready) begin
                if (got < 5) begin
                    chk("bp_bit", 16'(out_bit), 16'(be[got]));
                    chk("bp_op", 16'(out_op), 16'(bo[got]));
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_sent", 16'(sent), 16'd5);
        chk("bp_got", 16'(got), 16'd5);

        // Reset with two operands in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h00; in_op = 2'b01;
        cyc();
        in_op = 2'b10;
        cyc();
        in_valid = 1'b0;
        rst_n = 1'b0;
        cyc();
        chk("mrst_valid", 16'(out_valid), 16'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h01; in_op = 2'b00;
        cyc();
        in_valid = 1'b0;
        chk("mrst_lat", 16'(out_valid), 16'd0);
        cyc();
        chk("mrst_v", 16'(out_valid), 16'd1);
        chk("mrst_bit", 16'(out_bit), 16'd1);
        chk("mrst_op", 16'(out_op), 16'd0);
        cyc();
        chk("mrst_empty", 16'(out_valid), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
